// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode encodings, the timing-set struct and FSM states shared by vga_mode_ctrl.
// Latency: none (types and constants only).
// Backpressure: none.
package vga_timing_pkg;

  localparam logic MODE_800x600 = 1'b0;
  localparam logic MODE_640x480 = 1'b1;

  // One complete generator configuration: horizontal and vertical
  // visible/front-porch/sync/back-porch counts plus the pixel clock divider.
  typedef struct packed {
    logic [11:0] viz_h;
    logic [11:0] fr_h;
    logic [11:0] sy_h;
    logic [11:0] bk_h;
    logic [11:0] viz_v;
    logic [11:0] fr_v;
    logic [11:0] sy_v;
    logic [11:0] bk_v;
    logic [1:0]  div_val;
  } vga_cfg_t;

  localparam vga_cfg_t CFG_800x600 = '{
    viz_h: 12'd800, fr_h: 12'd56, sy_h: 12'd120, bk_h: 12'd64,
    viz_v: 12'd600, fr_v: 12'd37, sy_v: 12'd6,   bk_v: 12'd23,
    div_val: 2'd1
  };

  localparam vga_cfg_t CFG_640x480 = '{
    viz_h: 12'd640, fr_h: 12'd16, sy_h: 12'd96,  bk_h: 12'd48,
    viz_v: 12'd480, fr_v: 12'd10, sy_v: 12'd2,   bk_v: 12'd33,
    div_val: 2'd2
  };

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    IDLE    = 2'd1,
    PENDING = 2'd2,
    BLANK   = 2'd3
  } vga_state_t;

  function automatic vga_cfg_t cfg_for_mode(input logic mode);
    return (mode == MODE_640x480) ? CFG_640x480 : CFG_800x600;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a consecutive-sample debounce filter.
// Latency: an input edge reaches filt 2+DEB_CYCLES clocks after it is first sampled.
// Backpressure: none; free-running, one sample per clock.
// Ports: CLK clock, RST sync active-high reset, raw async level in, filt filtered level out.
module sync_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic filt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts earlier consecutive samples that disagreed with filt; the
  // DEB_CYCLES-th disagreeing sample in a row updates filt. The run restarts
  // after an update, so cnt never exceeds DEB_CYCLES-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: sequences VGA mode changes; holds the timing generators in reset while a new set loads.
// Latency: mode edge -> BUSY in 3+DEB_CYCLES clocks; load on the next FRAME_END; TG_RST released BLANK_CYCLES later.
// Backpressure: a requested switch waits in PENDING for FRAME_END; a reverted request cancels it.
// Ports: CLK, RST (sync active-high), MODE (async switch), FRAME_END (last-cycle pulse);
//        VIZ/FR/SY/BK_H/V + DIV_VAL configuration, TG_RST, MODE_CUR, BUSY, CHANGED (all registered).
// Optional: define VGA_MODE_TIMEOUT_EN to force the load after TIMEOUT_CYCLES in PENDING.
module vga_mode_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int BLANK_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MODE,
  input  logic        FRAME_END,
  output logic [11:0] VIZ_H,
  output logic [11:0] FR_H,
  output logic [11:0] SY_H,
  output logic [11:0] BK_H,
  output logic [11:0] VIZ_V,
  output logic [11:0] FR_V,
  output logic [11:0] SY_V,
  output logic [11:0] BK_V,
  output logic [1:0]  DIV_VAL,
  output logic        TG_RST,
  output logic        MODE_CUR,
  output logic        BUSY,
  output logic        CHANGED
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("vga_mode_ctrl: DEB_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("vga_mode_ctrl: BLANK_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("vga_mode_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  logic          mode_filt;
  vga_state_t    state;
  vga_cfg_t      cfg;
  logic [BW-1:0] blank_cnt;
  logic          load_go;

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_mode_deb (
    .CLK  (CLK),
    .RST  (RST),
    .raw  (MODE),
    .filt (mode_filt)
  );

`ifdef VGA_MODE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] pend_cnt;
  logic          pend_tmo;

  assign pend_tmo = (pend_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Cycles spent in PENDING; held at zero elsewhere so every entry starts
  // fresh, and saturates at the timeout value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_cnt <= '0;
    end else if (state != PENDING) begin
      pend_cnt <= '0;
    end else if (!pend_tmo) begin
      pend_cnt <= pend_cnt + TW'(1);
    end
  end

  // A stalled vertical generator is treated as if it had ended its frame.
  assign load_go = FRAME_END | pend_tmo;
`else
  assign load_go = FRAME_END;
`endif

  // Configuration is only written at reset and on the PENDING->BLANK edge,
  // both of which leave TG_RST high, so the generators never see it move
  // while running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= STARTUP;
      cfg       <= CFG_800x600;
      MODE_CUR  <= MODE_800x600;
      TG_RST    <= 1'b1;
      BUSY      <= 1'b1;
      CHANGED   <= 1'b0;
      blank_cnt <= '0;
    end else begin
      CHANGED <= 1'b0;
      case (state)
        STARTUP: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state     <= IDLE;
            TG_RST    <= 1'b0;
            BUSY      <= 1'b0;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        IDLE: begin
          if (mode_filt != MODE_CUR) begin
            state <= PENDING;
            BUSY  <= 1'b1;
          end
        end

        PENDING: begin
          // A request that has reverted wins over a coincident frame end.
          if (mode_filt == MODE_CUR) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (load_go) begin
            state     <= BLANK;
            TG_RST    <= 1'b1;
            cfg       <= cfg_for_mode(mode_filt);
            MODE_CUR  <= mode_filt;
            blank_cnt <= '0;
          end
        end

        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state     <= IDLE;
            TG_RST    <= 1'b0;
            BUSY      <= 1'b0;
            CHANGED   <= 1'b1;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        default: begin
          state     <= STARTUP;
          TG_RST    <= 1'b1;
          BUSY      <= 1'b1;
          blank_cnt <= '0;
        end
      endcase
    end
  end

  assign VIZ_H   = cfg.viz_h;
  assign FR_H    = cfg.fr_h;
  assign SY_H    = cfg.sy_h;
  assign BK_H    = cfg.bk_h;
  assign VIZ_V   = cfg.viz_v;
  assign FR_V    = cfg.fr_v;
  assign SY_V    = cfg.sy_v;
  assign BK_V    = cfg.bk_v;
  assign DIV_VAL = cfg.div_val;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// tb_vga_mode_ctrl: directed test-plan scenarios plus a randomized MODE/FRAME_END/RST soak.
// Inputs change on the falling edge; outputs are compared on the falling edge against a
// behavioural model advanced on each rising edge.
module tb_vga_mode_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int TMO = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MODE = 1'b0;
  logic        FRAME_END = 1'b0;
  logic [11:0] VIZ_H, FR_H, SY_H, BK_H, VIZ_V, FR_V, SY_V, BK_V;
  logic [1:0]  DIV_VAL;
  logic        TG_RST, MODE_CUR, BUSY, CHANGED;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_mode_ctrl #(
    .DEB_CYCLES     (DEB),
    .BLANK_CYCLES   (BLK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MODE      (MODE),
    .FRAME_END (FRAME_END),
    .VIZ_H     (VIZ_H),
    .FR_H      (FR_H),
    .SY_H      (SY_H),
    .BK_H      (BK_H),
    .VIZ_V     (VIZ_V),
    .FR_V      (FR_V),
    .SY_V      (SY_V),
    .BK_V      (BK_V),
    .DIV_VAL   (DIV_VAL),
    .TG_RST    (TG_RST),
    .MODE_CUR  (MODE_CUR),
    .BUSY      (BUSY),
    .CHANGED   (CHANGED)
  );

  always #5 CLK = ~CLK;

  localparam logic [97:0] SET0 = {12'd800, 12'd56, 12'd120, 12'd64,
                                  12'd600, 12'd37, 12'd6,   12'd23, 2'd1};
  localparam logic [97:0] SET1 = {12'd640, 12'd16, 12'd96,  12'd48,
                                  12'd480, 12'd10, 12'd2,   12'd33, 2'd2};

  function automatic logic [97:0] cfg_ref(input bit m);
    return m ? SET1 : SET0;
  endfunction

  function automatic logic [97:0] cfg_obs();
    return {VIZ_H, FR_H, SY_H, BK_H, VIZ_V, FR_V, SY_V, BK_V, DIV_VAL};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Filter: MODE seen two clocks late; the filtered level follows once DEB
  // consecutive samples disagree with it. Controller: a live mode, a pending
  // request flag, and a countdown of remaining reset-hold cycles.
  bit seen_q[$] = '{1'b0, 1'b0};
  bit m_filt = 1'b0;
  int m_streak = 0;
  int m_hold = BLK;
  bit m_wait = 1'b0;
  bit m_live = 1'b0;
  bit m_startup = 1'b1;
  int m_age = 0;
  bit e_tg = 1'b1;
  bit e_busy = 1'b1;
  bit e_chg = 1'b0;

  always @(posedge CLK) begin
    bit seen;
    bit f;
    bit tmo;
    cyc++;
    if (RST) begin
      seen_q = '{1'b0, 1'b0};
      m_filt = 1'b0; m_streak = 0;
      m_hold = BLK; m_wait = 1'b0; m_live = 1'b0; m_startup = 1'b1; m_age = 0;
      e_tg = 1'b1; e_busy = 1'b1; e_chg = 1'b0;
    end else begin
      seen = seen_q[1];
      seen_q.push_front(MODE);
      void'(seen_q.pop_back());
      f = m_filt;
`ifdef VGA_MODE_TIMEOUT_EN
      tmo = (m_age >= TMO - 1);
`else
      tmo = 1'b0;
`endif
      e_chg = 1'b0;
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          e_tg = 1'b0; e_busy = 1'b0;
          e_chg = !m_startup;
          m_startup = 1'b0;
        end
      end else if (!m_wait) begin
        if (f != m_live) begin
          m_wait = 1'b1; e_busy = 1'b1; m_age = 0;
        end
      end else begin
        if (f == m_live) begin
          m_wait = 1'b0; e_busy = 1'b0;
        end else if (FRAME_END || tmo) begin
          m_wait = 1'b0; m_live = f; e_tg = 1'b1; m_hold = BLK;
        end else begin
          m_age++;
        end
      end
      if (seen != m_filt) m_streak++;
      else m_streak = 0;
      if (m_streak == DEB) begin
        m_filt = seen; m_streak = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
    chk("mdl_cfg", 128'(cfg_obs()), 128'(cfg_ref(m_live)));
    chk("mdl_ctl", 128'({TG_RST, BUSY, CHANGED, MODE_CUR}), 128'({e_tg, e_busy, e_chg, m_live}));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (BUSY !== val && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 128'(BUSY), 128'(val));
  endtask

  task automatic pulse_fe();
    FRAME_END = 1'b1;
    tick();
    FRAME_END = 1'b0;
  endtask

  initial begin
    int t;
    int hi;
    int chg;
    int n;
    int hold;

    // 1. reset / startup
    tick_n(3);
    chk("rst_cfg", 128'(cfg_obs()), 128'(SET0));
    chk("rst_ctl", 128'({TG_RST, BUSY, CHANGED, MODE_CUR}), 128'(4'b1100));
    RST = 1'b0;
    hi = TG_RST ? 1 : 0;
    chg = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (TG_RST) hi++;
      if (CHANGED) chg++;
    end
    chk("start_tg_len", 128'(hi), 128'(8));
    chk("start_no_chg", 128'(chg), 128'(0));
    chk("start_busy", 128'(BUSY), 128'(0));

    // 3. glitch shorter than the debounce window
    MODE = 1'b1;
    tick_n(3);
    MODE = 1'b0;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (BUSY) hi++;
    end
    chk("glitch_busy", 128'(hi), 128'(0));
    chk("glitch_cfg", 128'(cfg_obs()), 128'(SET0));

    // 2. normal 0->1 switch
    MODE = 1'b1;
    t = cyc;
    tick_n(6);
    chk("sw_busy_t6", 128'(BUSY), 128'(0));
    tick();
    chk("sw_busy_t7", 128'(BUSY), 128'(1));
    while (cyc < t + 40) tick();
    pulse_fe();
    chk("sw_tg_t41", 128'(TG_RST), 128'(1));
    chk("sw_cfg_t41", 128'(cfg_obs()), 128'(SET1));
    chk("sw_cur_t41", 128'(MODE_CUR), 128'(1));
    tick_n(7);
    chk("sw_tg_t48", 128'({TG_RST, CHANGED}), 128'(2'b10));
    tick();
    chk("sw_tg_t49", 128'({TG_RST, CHANGED}), 128'(2'b01));
    tick();
    chk("sw_chg_t50", 128'(CHANGED), 128'(0));

    // 4. cancel, with a FRAME_END in the cancel cycle
    MODE = 1'b0;
    wait_busy(1'b1, 30, "cancel_pending");
    MODE = 1'b1;
    tick_n(6);
    chk("cancel_still_busy", 128'(BUSY), 128'(1));
    pulse_fe();
    chk("cancel_idle", 128'({TG_RST, BUSY, MODE_CUR}), 128'(3'b001));
    chk("cancel_cfg", 128'(cfg_obs()), 128'(SET1));
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TG_RST) hi++;
    end
    chk("cancel_no_tg", 128'(hi), 128'(0));

    // 5. reset in the middle of BLANK of a 0->1 switch
    MODE = 1'b0;
    wait_busy(1'b1, 30, "r5_req0");
    pulse_fe();
    wait_busy(1'b0, 30, "r5_done0");
    MODE = 1'b1;
    wait_busy(1'b1, 30, "r5_req1");
    pulse_fe();
    chk("r5_blank_tg", 128'(TG_RST), 128'(1));
    tick_n(3);
    RST = 1'b1;
    tick_n(2);
    chk("r5_rst_cfg", 128'(cfg_obs()), 128'(SET0));
    chk("r5_rst_ctl", 128'({TG_RST, BUSY, MODE_CUR}), 128'(3'b110));
    RST = 1'b0;
    n = 0;
    while (TG_RST !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("r5_startup_end", 128'({TG_RST, MODE_CUR}), 128'(2'b00));
    wait_busy(1'b1, 30, "r5_re_req");
    pulse_fe();
    chk("r5_load1", 128'({TG_RST, MODE_CUR}), 128'(2'b11));
    chk("r5_cfg1", 128'(cfg_obs()), 128'(SET1));
    wait_busy(1'b0, 30, "r5_done1");

    // 6. PENDING without FRAME_END
    MODE = 1'b0;
    wait_busy(1'b1, 30, "tmo_req");
`ifdef VGA_MODE_TIMEOUT_EN
    n = 0;
    while (TG_RST !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("tmo_delay", 128'(n), 128'(TMO));
    chk("tmo_cfg", 128'(cfg_obs()), 128'(SET0));
`else
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (TG_RST) hi++;
    end
    chk("no_tmo_tg", 128'(hi), 128'(0));
    pulse_fe();
    chk("no_tmo_load", 128'({TG_RST, MODE_CUR}), 128'(2'b10));
`endif
    wait_busy(1'b0, 30, "tmo_done");

    // randomized soak
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        MODE = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      FRAME_END = ($urandom_range(0, 24) == 0);
      RST = ($urandom_range(0, 999) == 0);
      tick();
    end
    RST = 1'b0;
    FRAME_END = 1'b0;
    tick_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
- Sequences video-mode changes for the VGA timing path: the horizontal/vertical sync generators and the pixel clock divider.
- Filters and synchronises the MODE switch, then waits for the end of the current frame.
- Holds the timing generators in reset, loads the new timing set, and releases them.
- Sits between the board MODE input and the generator configuration inputs. It replaces the free-running per-cycle parameter mux.

Parameters:
- DEB_CYCLES, 4: consecutive cycles the synchronised MODE must differ from the filtered value before the filtered value updates (>=1).
- BLANK_CYCLES, 8: cycles TG_RST is held after a load (>=1).
- TIMEOUT_CYCLES, 2000000: PENDING timeout; used only with the optional feature.

Ports:
- CLK  in  1  system/pixel-source clock
- RST  in  1  synchronous, active-high reset
- MODE  in  1  asynchronous mode switch: 0 = 800x600, 1 = 640x480
- FRAME_END  in  1  one-cycle pulse from the vertical generator on the last cycle of a frame
- VIZ_H, FR_H, SY_H, BK_H  out  12 each  horizontal visible/front/sync/back counts
- VIZ_V, FR_V, SY_V, BK_V  out  12 each  vertical visible/front/sync/back counts
- DIV_VAL  out  2  pixel clock divider value
- TG_RST  out  1  reset to both timing generators and the divider
- MODE_CUR  out  1  mode currently loaded
- BUSY  out  1  1 whenever the state is not IDLE
- CHANGED  out  1  one-cycle pulse when a new mode goes live

Behaviour:
- **Reset values:**
  - Configuration outputs take the mode-0 set: 800/56/120/64, 600/37/6/23, DIV_VAL=1.
  - MODE_CUR=0, TG_RST=1, BUSY=1, CHANGED=0.
  - Synchroniser flops=0, filtered mode=0, state=STARTUP, counters=0.
- **Reset mid-operation:**
  - Any in-progress switch is abandoned.
  - Mode 0 is forced regardless of the MODE pin. If MODE=1, a normal switch follows once the controller is back in IDLE.
- **Input filter:**
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while sync != filtered and clears when they are equal.
  - Filtered takes the sync value when the counter reaches DEB_CYCLES-1.
  - A MODE edge sampled at clock t therefore changes the filtered value at t+2+DEB_CYCLES.
- **STARTUP:**
  - TG_RST=1 for BLANK_CYCLES cycles, then go to IDLE.
  - On leaving: TG_RST=0, BUSY=0, no CHANGED pulse.
- **IDLE:**
  - If filtered != MODE_CUR, go to PENDING next cycle.
  - BUSY=1 at t+3+DEB_CYCLES.
- **PENDING:**
  - If filtered == MODE_CUR, cancel back to IDLE; the cancel has priority over FRAME_END in the same cycle.
  - Otherwise, on FRAME_END=1 go to BLANK.
  - On that same edge: TG_RST<=1, all configuration outputs load the target set, MODE_CUR<=filtered.
- **BLANK:**
  - Counts BLANK_CYCLES cycles with TG_RST=1, then goes to IDLE.
  - On that edge: TG_RST<=0, CHANGED<=1 for exactly one cycle.
- **FRAME_END:** ignored outside PENDING.
- **Stability guarantee:** configuration outputs change only on the PENDING->BLANK edge or at reset, so they are never modified while TG_RST=0.
- **MODE change during BLANK:** not acted on until IDLE. It is then re-evaluated, so a toggle-back causes a second switch.
- **Mode-1 set:** 640/16/96/48, 480/10/2/33, DIV_VAL=2.
- **Counters:** counter widths are $clog2 of their parameters. Counters saturate and do not wrap.

Optional Feature:
- Macro: VGA_MODE_TIMEOUT_EN.
- **When defined:**
  - A PENDING counter counts cycles spent in PENDING.
  - Once it reaches TIMEOUT_CYCLES-1 with no FRAME_END, the transition to BLANK is forced exactly as if FRAME_END had occurred. This covers a stalled or unclocked vertical generator.
  - The counter clears on entry to PENDING.
- **When undefined:** PENDING waits indefinitely for FRAME_END, and the counter logic is absent.

Decomposition:
- Package vga_timing_pkg holds:
  - mode encoding constants MODE_800x600=0 and MODE_640x480=1;
  - a packed struct of the eight 12-bit counts plus the 2-bit divider;
  - localparam instances for both modes;
  - the state enum STARTUP/IDLE/PENDING/BLANK.
- One sub-module, sync_debounce (synchroniser plus debounce counter, parameter DEB_CYCLES), is natural and reusable for the other board switches.

Test Plan:
1. **Reset/startup:** hold RST 3 cycles with MODE=0, then release.
   - Outputs read 800/56/120/64/600/37/6/23 with DIV_VAL=1.
   - TG_RST=1 for 8 cycles, then 0; BUSY falls with TG_RST; CHANGED never pulses.
2. **Normal switch:** MODE 0->1 at cycle t, FRAME_END pulse at t+40.
   - BUSY=1 at t+7.
   - At t+41: TG_RST=1 and configuration = 640/16/96/48/480/10/2/33, DIV_VAL=2, MODE_CUR=1.
   - At t+49: TG_RST=0 with one CHANGED pulse.
3. **Glitch rejection:** MODE high for 3 cycles, then low.
   - BUSY stays 0; no output changes.
4. **Cancel:** MODE 0->1, wait until PENDING, then MODE back to 0 with no FRAME_END.
   - Returns to IDLE; configuration unchanged.
   - A FRAME_END in the same cycle as the cancel is ignored.
5. **Reset mid-BLANK:** assert RST during BLANK of a 0->1 switch while MODE=1.
   - Mode-0 set is restored, followed by STARTUP.
   - The 1-switch completes at the first subsequent FRAME_END.
6. **With VGA_MODE_TIMEOUT_EN, TIMEOUT_CYCLES=100:** request a switch and never pulse FRAME_END.
   - TG_RST rises exactly 100 cycles after PENDING entry.
   - Without the macro, TG_RST stays 0 for 1000 cycles.
